// File: rtl/hazard_issue_scheduler_if.sv
// Decode-to-issue bus for hazard_issue_scheduler. Decode drives the master side.
// Handshake: an instruction is accepted on a cycle where id_valid && id_ready; id_ready is combinational.
interface hazard_issue_scheduler_if #(
    parameter int NREGS = 16
);
    logic             id_valid;
    logic [NREGS-1:0] id_req;
    logic [NREGS-1:0] id_prov;
    logic             flush;
    logic             id_ready;
    logic             issue_valid;
    logic [NREGS-1:0] issue_prov;
    logic [NREGS-1:0] busy_mask;
    logic [1:0]       state;
    logic [15:0]      stall_cnt;

    modport master (
        output id_valid, id_req, id_prov, flush,
        input  id_ready, issue_valid, issue_prov, busy_mask, state, stall_cnt
    );

    modport slave (
        input  id_valid, id_req, id_prov, flush,
        output id_ready, issue_valid, issue_prov, busy_mask, state, stall_cnt
    );
endinterface

// File: rtl/hazard_issue_scheduler.sv
// RAW/WAW issue scheduler with a fixed-latency shadow pipeline of destination masks.
// Optional macro HAZ_BYPASS_EN: writeback forwarding, so the last slot no longer blocks.
module hazard_issue_scheduler #(
    parameter int NREGS = 16,
    parameter int DEPTH = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    hazard_issue_scheduler_if.slave  bus
);

`ifdef HAZ_BYPASS_EN
    localparam int BUSY_SLOTS = DEPTH - 1;
`else
    localparam int BUSY_SLOTS = DEPTH;
`endif

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    state_e           r_state;
    state_e           w_state_nxt;
    logic [NREGS-1:0] r_slot [DEPTH];
    logic             r_issue_valid;
    logic [15:0]      r_stall_cnt;
    logic [NREGS-1:0] w_busy;
    logic             w_hazard;
    logic             w_ready;
    logic             w_accept;

    always_comb begin
        w_busy = '0;
        for (int i = 0; i < BUSY_SLOTS; i++) begin
            w_busy = w_busy | r_slot[i];
        end
    end

    assign w_hazard = |((bus.id_req | bus.id_prov) & w_busy);
    assign w_ready  = bus.id_valid & ~w_hazard & ~bus.flush & (r_state != ST_FLUSH);
    assign w_accept = bus.id_valid & w_ready;

    always_comb begin
        w_state_nxt = r_state;
        if (bus.flush) begin
            w_state_nxt = ST_FLUSH;
        end else begin
            case (r_state)
                ST_RUN:   if (bus.id_valid && w_hazard) w_state_nxt = ST_STALL;
                ST_STALL: if (!w_hazard) w_state_nxt = ST_RUN;
                ST_FLUSH: w_state_nxt = ST_RUN;
                default:  w_state_nxt = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_RUN;
            r_issue_valid <= 1'b0;
            r_stall_cnt   <= '0;
            for (int i = 0; i < DEPTH; i++) r_slot[i] <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_issue_valid <= w_accept;
            if (bus.id_valid && !w_ready && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
            // A flush wipes every in-flight entry; w_accept is already 0 then.
            if (bus.flush) begin
                for (int i = 0; i < DEPTH; i++) r_slot[i] <= '0;
            end else begin
                r_slot[0] <= w_accept ? bus.id_prov : '0;
                for (int i = 1; i < DEPTH; i++) r_slot[i] <= r_slot[i-1];
            end
        end
    end

    assign bus.id_ready    = w_ready;
    assign bus.issue_valid = r_issue_valid;
    assign bus.issue_prov  = r_slot[0];
    assign bus.busy_mask   = w_busy;
    assign bus.state       = r_state;
    assign bus.stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_hazard_issue_scheduler.sv
// Self-checking bench for hazard_issue_scheduler: directed test-plan steps plus random traffic
// checked every cycle against an age-based model of in-flight writers.
module tb_hazard_issue_scheduler;
  localparam int NREGS = 16;
  localparam int DEPTH = 3;
`ifdef HAZ_BYPASS_EN
  localparam int WIN = DEPTH - 1;
`else
  localparam int WIN = DEPTH;
`endif

  typedef struct {
    int          c;
    logic [15:0] p;
  } wr_t;

  logic clk;
  logic reset;
  hazard_issue_scheduler_if #(.NREGS(NREGS)) bus();

  hazard_issue_scheduler #(.NREGS(NREGS), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model state
  wr_t         wq[$];
  int          now;
  int          m_mode;
  int          m_cnt;
  logic        m_iv;
  logic [15:0] m_ip;
  logic        chk_on;
  int          n_pass;
  int          n_total;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, now, obs, exp);
  endtask

  // One clock cycle: drive, check mid-cycle, advance the model at the edge.
  task automatic cyc(input logic v, input logic [15:0] rq, input logic [15:0] pv,
                     input logic fl, input logic rs);
    logic [15:0] mb;
    logic        hz;
    logic        rdy;
    bus.id_valid = v;
    bus.id_req   = rq;
    bus.id_prov  = pv;
    bus.flush    = fl;
    reset        = rs;
    #4;
    mb = '0;
    foreach (wq[i]) if (now - wq[i].c <= WIN) mb |= wq[i].p;
    hz  = |((rq | pv) & mb);
    rdy = v & !hz & !fl & (m_mode != 2);
    if (chk_on) begin
      check("busy_mask",   {16'd0, bus.busy_mask},  {16'd0, mb});
      check("id_ready",    {31'd0, bus.id_ready},   {31'd0, rdy});
      check("issue_valid", {31'd0, bus.issue_valid}, {31'd0, m_iv});
      check("issue_prov",  {16'd0, bus.issue_prov}, {16'd0, m_ip});
      check("state",       {30'd0, bus.state},      m_mode);
      check("stall_cnt",   {16'd0, bus.stall_cnt},  m_cnt);
    end
    @(posedge clk);
    if (rs) begin
      wq.delete();
      m_mode = 0;
      m_cnt  = 0;
      m_iv   = 1'b0;
      m_ip   = '0;
    end else begin
      if (v && !rdy && m_cnt < 65535) m_cnt++;
      m_iv = rdy;
      m_ip = rdy ? pv : 16'h0;
      if (fl) wq.delete();
      else if (rdy && pv != 0) wq.push_back('{now, pv});
      if (fl) m_mode = 2;
      else if (m_mode == 2) m_mode = 0;
      else if (hz && (m_mode == 1 || v)) m_mode = 1;
      else m_mode = 0;
    end
    while (wq.size() > 0 && (now + 1 - wq[0].c) > WIN) void'(wq.pop_front());
    now++;
    #1;
  endtask

  initial begin
    int c0;
    logic [15:0] a, b;
    n_pass = 0; n_total = 0; now = 0; chk_on = 1'b0;
    m_mode = 0; m_cnt = 0; m_iv = 1'b0; m_ip = '0;
    bus.id_valid = 1'b0; bus.id_req = '0; bus.id_prov = '0; bus.flush = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    cyc(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    chk_on = 1'b1;

    // basic issue with one-cycle latency
    cyc(1'b1, 16'h0001, 16'h0002, 1'b0, 1'b0);
    check("t1_issue_valid", {31'd0, bus.issue_valid}, 32'd1);
    check("t1_issue_prov",  {16'd0, bus.issue_prov},  32'h2);
    check("t1_stall_cnt",   {16'd0, bus.stall_cnt},   32'd0);
    cyc(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    repeat (3) cyc(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);

    // RAW stall
    c0 = m_cnt;
    cyc(1'b1, 16'h0000, 16'h0002, 1'b0, 1'b0);
    repeat (WIN + 1) cyc(1'b1, 16'h0002, 16'h0000, 1'b0, 1'b0);
    check("raw_stall_cycles", {16'd0, bus.stall_cnt} - c0, WIN);
    check("raw_issue_valid",  {31'd0, bus.issue_valid}, 32'd1);
    check("raw_state_run",    {30'd0, bus.state}, 32'd0);

    // WAW stall
    c0 = m_cnt;
    cyc(1'b1, 16'h0000, 16'h0010, 1'b0, 1'b0);
    cyc(1'b1, 16'h0000, 16'h0010, 1'b0, 1'b0);
    check("waw_busy", {16'd0, bus.busy_mask}, 32'h10);
    check("waw_state_stall", {30'd0, bus.state}, 32'd1);
    repeat (WIN) cyc(1'b1, 16'h0000, 16'h0010, 1'b0, 1'b0);
    check("waw_stall_cycles", {16'd0, bus.stall_cnt} - c0, WIN);
    repeat (DEPTH + 1) cyc(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);

    // flush during a stall
    cyc(1'b1, 16'h0000, 16'h0004, 1'b0, 1'b0);
    cyc(1'b1, 16'h0004, 16'h0000, 1'b0, 1'b0);
    cyc(1'b1, 16'h0004, 16'h0000, 1'b1, 1'b0);
    check("flush_state", {30'd0, bus.state}, 32'd2);
    check("flush_busy",  {16'd0, bus.busy_mask}, 32'h0);
    cyc(1'b1, 16'h0004, 16'h0000, 1'b0, 1'b0);
    cyc(1'b1, 16'h0004, 16'h0000, 1'b0, 1'b0);
    check("flush_after_issue", {31'd0, bus.issue_valid}, 32'd1);

    // reset during a stall
    cyc(1'b1, 16'h0000, 16'h0008, 1'b0, 1'b0);
    cyc(1'b1, 16'h0008, 16'h0000, 1'b0, 1'b0);
    cyc(1'b1, 16'h0008, 16'h0000, 1'b0, 1'b1);
    check("rst_state", {30'd0, bus.state}, 32'd0);
    check("rst_cnt",   {16'd0, bus.stall_cnt}, 32'd0);
    check("rst_busy",  {16'd0, bus.busy_mask}, 32'h0);
    cyc(1'b1, 16'h0008, 16'h0000, 1'b0, 1'b0);
    check("rst_after_issue", {31'd0, bus.issue_valid}, 32'd1);

    // random traffic
    for (int k = 0; k < 3000; k++) begin
      a = ($urandom_range(0, 3) == 0) ? 16'h0 : (16'h1 << $urandom_range(0, 3));
      b = ($urandom_range(0, 2) == 0) ? 16'h0 : (16'h1 << $urandom_range(0, 3));
      cyc(1'($urandom_range(0, 3) != 0), a, b,
          1'($urandom_range(0, 24) == 0), 1'($urandom_range(0, 199) == 0));
    end

    // saturation: a held flush keeps id_ready low indefinitely
    cyc(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    repeat (70000) cyc(1'b1, 16'h0001, 16'h0002, 1'b1, 1'b0);
    check("sat_cnt", {16'd0, bus.stall_cnt}, 32'hFFFF);
    cyc(1'b1, 16'h0001, 16'h0002, 1'b0, 1'b0);
    cyc(1'b1, 16'h0001, 16'h0002, 1'b0, 1'b0);
    check("sat_hold", {16'd0, bus.stall_cnt}, 32'hFFFF);
    check("sat_issue", {31'd0, bus.issue_valid}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
